lap_timer: RTL

LAP_TIMER -- requirements
Module: lap_timer

---
 rtl/lap_timer_pkg.sv | 23 ++
 rtl/lap_timer_bcd_digit.sv | 58 +++++
 rtl/lap_timer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lap_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lap_timer_pkg
// Description : Shared types and constants for the lap timer: FSM state
//               encoding, BCD digit type and the decimal digit modulus.
//               Configuration macro LAP_TIMER_LAP_EN (used by lap_timer)
//               enables the LAPPED state and the lap capture register.
// Revision    : 1.0 - initial release
// ============================================================================
package lap_timer_pkg;

  localparam int DEC_MOD = 10;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_LAPPED  = 2'b10
  } lap_state_e;

endpackage : lap_timer_pkg
`default_nettype wire

// File: rtl/lap_timer_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One cascadable up/down counter digit with modulus MOD.
// Ports       : clk    - clock
//               reset  - synchronous active-high reset
//               clr    - synchronous clear to 0
//               step   - advance by one in the direction given by down
//               down   - 0 = increment, 1 = decrement
//               value  - current digit value (0..MOD-1)
//               carry  - combinational: step and digit at its terminal value
//                        (MOD-1 counting up, 0 counting down)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
  import lap_timer_pkg::*;
#(
  parameter int MOD = DEC_MOD
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic step,
  input  logic down,
  output bcd_t value,
  output logic carry
);

  localparam bcd_t MAX_VAL = bcd_t'(MOD - 1);

  bcd_t value_q, value_d;
  logic at_term;

  always_comb begin
    at_term = down ? (value_q == '0) : (value_q == MAX_VAL);
    value_d = value_q;
    if (step) begin
      if (at_term) begin
        value_d = down ? MAX_VAL : '0;
      end else begin
        value_d = down ? (value_q - 4'd1) : (value_q + 4'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = step & at_term;

endmodule : bcd_digit
`default_nettype wire

// File: rtl/lap_timer.sv
`default_nettype none
// ============================================================================
// Module      : lap_timer
// Description : Cascaded BCD up/down stopwatch with prescaler, rollover
//               pulse and optional lap-hold display.
//               Macro LAP_TIMER_LAP_EN compiles in the LAPPED state and the
//               lap capture register; without it lap is ignored and the
//               display is always live.
// Ports       : clk     - sole clock
//               reset   - synchronous active-high reset
//               go      - count enable (level)
//               clr     - synchronous clear of count and prescaler
//               down    - count direction, sampled on tick cycles
//               lap     - single-cycle lap toggle pulse
//               digits  - displayed BCD value, digit 0 in [3:0]
//               wrap    - one-cycle pulse after full-chain roll/underflow
//               running - high in RUNNING or LAPPED
// Revision    : 1.0 - initial release
// ============================================================================
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000000,
  parameter int TOP_MOD    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic                    clr,
  input  logic                    down,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    wrap,
  output logic                    running
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  lap_state_e              state_q;
  logic                    running_q;
  logic                    wrap_q;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick;
  // step_chain[0] is the prescaler tick; step_chain[k+1] is digit k's carry,
  // so step_chain[NUM_DIGITS] marks a full-chain rollover/underflow.
  logic [NUM_DIGITS:0]     step_chain;
  logic [4*NUM_DIGITS-1:0] live;

  // --------------------------------------------------------------------------
  // Prescaler: advances whenever go is high (including the cycle that
  // starts the FSM), so a resume from STOPPED keeps the tick phase.
  // --------------------------------------------------------------------------
  always_comb begin
    tick    = go && (presc_q == PRESC_MAX) && !clr;
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (go) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Digit chain
  // --------------------------------------------------------------------------
  assign step_chain[0] = tick;

  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      localparam int DIG_MOD = (k == NUM_DIGITS - 1) ? TOP_MOD : DEC_MOD;
      bcd_digit #(
        .MOD (DIG_MOD)
      ) u_digit (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .step  (step_chain[k]),
        .down  (down),
        .value (live[4*k +: 4]),
        .carry (step_chain[k+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= step_chain[NUM_DIGITS];
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered running flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_STOPPED;
      running_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_STOPPED: begin
          if (go) begin
            state_q   <= ST_RUNNING;
            running_q <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (!go) begin
            state_q   <= ST_STOPPED;
            running_q <= 1'b0;
          end
`ifdef LAP_TIMER_LAP_EN
          else if (lap) begin
            state_q <= ST_LAPPED;
          end
`endif
        end
`ifdef LAP_TIMER_LAP_EN
        ST_LAPPED: begin
          if (!go) begin
            state_q   <= ST_STOPPED;
            running_q <= 1'b0;
          end else if (lap) begin
            state_q <= ST_RUNNING;
          end
        end
`endif
        default: begin
          state_q   <= ST_STOPPED;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Display path
  // --------------------------------------------------------------------------
`ifdef LAP_TIMER_LAP_EN
  logic [4*NUM_DIGITS-1:0] cap_q;

  // Capture the pre-tick live value in the cycle the RUNNING->LAPPED
  // transition is taken.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cap_q <= '0;
    end else if ((state_q == ST_RUNNING) && go && lap) begin
      cap_q <= live;
    end
  end

  assign digits = (state_q == ST_LAPPED) ? cap_q : live;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign digits     = live;
`endif

  assign wrap    = wrap_q;
  assign running = running_q;

endmodule : lap_timer
`default_nettype wire
